// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop RX synchroniser, mid-bit sampling FSM,
// parity/framing/break detection and a valid/ready holding register.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 22274,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_EOF, S_BRK
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_out_q, ferr_out_q, ovr_q, brk_q;

  logic rx_s, sample, stop_last, par_bad;
  assign rx_s      = sync_q[1];
  assign sample    = (cnt_q == CNT_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_idx_q;
  // Odd mode inverts the sense of the even-parity check.
  assign par_bad   = (^{shift_q, rx_s}) ^ (PARITY == 2);

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      ovr_q  <= 1'b0;
      brk_q  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      if (valid_q && i_ready) valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= S_START;
        end
        S_START: if (cnt_q == CNT_HALF) begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          perr_q    <= 1'b0;
          ferr_q    <= 1'b0;
          state_q   <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (sample) begin
          cnt_q              <= '0;
          shift_q[bit_idx_q] <= rx_s;
          bit_idx_q          <= bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            stop_idx_q <= 1'b0;
            state_q    <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: if (sample) begin
          cnt_q   <= '0;
          perr_q  <= par_bad;
          state_q <= S_STOP;
        end
        S_STOP: if (sample) begin
          cnt_q      <= '0;
          stop_idx_q <= 1'b1;
          if (!rx_s) ferr_q <= 1'b1;
          if (stop_last) state_q <= S_EOF;
        end
        S_EOF: begin
          cnt_q <= '0;
          // Low line, all-zero data and a bad stop bit is a break, not a frame.
          if (ferr_q && shift_q == '0 && !rx_s) begin
            brk_q   <= 1'b1;
            state_q <= S_BRK;
          end else begin
            state_q <= S_IDLE;
            if (!valid_q || i_ready) begin
              data_q     <= shift_q;
              perr_out_q <= perr_q;
              ferr_out_q <= ferr_q;
              valid_q    <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        S_BRK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_overrun    = ovr_q;
  assign o_break      = brk_q;
endmodule
